// File: rtl/fir_filter_param_if.sv
// Sample, coefficient-write and result signals of one equalizer-band FIR filter.
// The master drives the i_* signals; the filter (slave) drives the o_* signals.
interface fir_filter_param_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int ADDR_WIDTH  = 6
);
  // Strobe protocol (no back-pressure): i_sample_valid offers one sample for
  // one cycle. It is taken only when the filter is idle; otherwise it is
  // dropped and o_overrun pulses. o_sample_valid pulses once per result.
  logic                          i_sample_valid;
  logic signed [DATA_WIDTH-1:0]  i_signal_sample;
  logic                          i_write_enable;
  logic [ADDR_WIDTH-1:0]         i_write_address;
  logic signed [COEFF_WIDTH-1:0] i_coeffs_in;
  logic                          i_write_done;
  logic signed [DATA_WIDTH-1:0]  o_signal_sample;
  logic                          o_sample_valid;
  logic                          o_busy;
  logic                          o_overrun;

  modport master (
    output i_sample_valid, i_signal_sample, i_write_enable,
    output i_write_address, i_coeffs_in, i_write_done,
    input  o_signal_sample, o_sample_valid, o_busy, o_overrun
  );

  modport slave (
    input  i_sample_valid, i_signal_sample, i_write_enable,
    input  i_write_address, i_coeffs_in, i_write_done,
    output o_signal_sample, o_sample_valid, o_busy, o_overrun
  );
endinterface

// File: rtl/fir_filter_param.sv
// Time-multiplexed single-MAC FIR filter with a double-buffered coefficient bank.
// Each accepted sample yields one rounded, saturated output after NUM_TAPS MAC cycles.
module fir_filter_param #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int COEFF_FRAC  = 15,
  parameter int NUM_TAPS    = 64,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_enable,
  fir_filter_param_if.slave bus,
  output logic [1:0]        state_dbg
);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
  localparam int ACC_W  = DATA_WIDTH + COEFF_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(NUM_TAPS - 1);
  localparam logic [ADDR_WIDTH-1:0] TAPS_A = ADDR_WIDTH'(NUM_TAPS);
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(64'sd1 <<< (COEFF_FRAC - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, DONE = 2'd2} state_t;

  state_t                        state;
  logic signed [DATA_WIDTH-1:0]  delay_line  [DEPTH];
  logic signed [COEFF_WIDTH-1:0] shadow_bank [DEPTH];
  logic signed [COEFF_WIDTH-1:0] active_bank [DEPTH];
  logic [ADDR_WIDTH-1:0]         wp;
  logic [ADDR_WIDTH-1:0]         k;
  logic signed [ACC_W-1:0]       acc;
  logic                          commit_pending;
  logic signed [DATA_WIDTH-1:0]  out_sample;
  logic                          out_valid;
  logic                          busy;
  logic                          overrun;

  logic [ADDR_WIDTH-1:0]         wp_next;
  logic [ADDR_WIDTH-1:0]         rd_idx;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       rnd_sum;
  logic signed [ACC_W-1:0]       shifted;
  logic signed [DATA_WIDTH-1:0]  sat_out;
  logic                          wr_ok;
  logic                          commit_now;

  assign wp_next = (wp == LAST) ? '0 : wp + ADDR_WIDTH'(1);
  // Modulo arithmetic on ADDR_WIDTH bits is exact because the true index < NUM_TAPS.
  assign rd_idx  = (wp >= k) ? (wp - k) : (wp + TAPS_A - k);
  assign prod    = PROD_W'(delay_line[rd_idx]) * PROD_W'(active_bank[k]);
  assign rnd_sum = acc + RND;
  assign shifted = rnd_sum >>> COEFF_FRAC;
  assign wr_ok   = bus.i_write_enable && (32'(bus.i_write_address) < NUM_TAPS);
  // A done pulse arriving in IDLE commits at once, so a coincident sample sees the new bank.
  assign commit_now = (state == IDLE) && (commit_pending || bus.i_write_done);

  always_comb begin
    sat_out = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX)      sat_out = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) sat_out = SAT_MIN[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      wp             <= '0;
      k              <= '0;
      acc            <= '0;
      commit_pending <= 1'b0;
      out_sample     <= '0;
      out_valid      <= 1'b0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        delay_line[i]  <= '0;
        shadow_bank[i] <= '0;
        active_bank[i] <= '0;
      end
    end else if (clk_enable) begin
      out_valid <= 1'b0;
      overrun   <= bus.i_sample_valid && (state != IDLE);
      if (wr_ok) shadow_bank[bus.i_write_address] <= bus.i_coeffs_in;
      if (bus.i_write_done) commit_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (commit_now) begin
            for (int i = 0; i < DEPTH; i++)
              active_bank[i] <= (wr_ok && bus.i_write_address == ADDR_WIDTH'(i)) ?
                                bus.i_coeffs_in : shadow_bank[i];
            commit_pending <= 1'b0;
          end
          if (bus.i_sample_valid) begin
            delay_line[wp_next] <= bus.i_signal_sample;
            wp    <= wp_next;
            acc   <= '0;
            k     <= '0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          if (k == LAST) state <= DONE;
          else           k     <= k + ADDR_WIDTH'(1);
        end
        DONE: begin
          out_sample <= sat_out;
          out_valid  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_signal_sample = out_sample;
  assign bus.o_sample_valid  = out_valid;
  assign bus.o_busy          = busy;
  assign bus.o_overrun       = overrun;
  assign state_dbg           = state;
endmodule

// File: tb/tb_fir_filter_param.sv
// Scoreboard bench for fir_filter_param built with 8 taps: a tap-ordered
// reference model predicts each output, which is compared when the DUT emits it.
module tb_fir_filter_param;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int CF = 15;
  localparam int NT = 8;
  localparam int AW = 4;
  localparam longint SMAX = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (DW - 1));

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       clk_enable;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  fir_filter_param_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .ADDR_WIDTH(AW)) bus ();

  fir_filter_param #(
    .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .COEFF_FRAC(CF), .NUM_TAPS(NT), .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_enable(clk_enable),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int raw_cycle = 0;
  always @(posedge clk) raw_cycle <= raw_cycle + 1;

  // ---------------- scoreboard state ----------------
  int checks    = 0;
  int failures  = 0;
  int valid_cnt = 0;
  int ovr_cnt   = 0;
  logic [DW-1:0] exp_q[$];
  int            acc_q[$];
  int            lat_q[$];
  logic [DW-1:0] m_exp;
  int            m_acc;
  int            m_lat;

  // Reference model: hist[0] is the newest sample, mh[k] multiplies hist[k].
  logic signed [CW-1:0] mh  [NT];
  logic signed [CW-1:0] msh [NT];
  logic signed [DW-1:0] hist[NT];
  bit                   mpend;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_out();
    longint s = 0;
    for (int t = 0; t < NT; t++) s += longint'(mh[t]) * longint'(hist[t]);
    s = (s + (longint'(1) <<< (CF - 1))) >>> CF;
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
    return DW'(s);
  endfunction

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin
      mh[t] = '0; msh[t] = '0; hist[t] = '0;
    end
    mpend = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (bus.o_overrun) ovr_cnt++;
    if (bus.o_sample_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        m_exp = exp_q.pop_front();
        m_acc = acc_q.pop_front();
        m_lat = lat_q.pop_front();
        check("sample", longint'($signed(bus.o_signal_sample)), longint'($signed(m_exp)));
        check("latency", raw_cycle - m_acc, m_lat);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_coeff(input int a, input int d, input bit done);
    @(negedge clk);
    bus.i_write_enable  = 1'b1;
    bus.i_write_address = AW'(a);
    bus.i_coeffs_in     = CW'(d);
    bus.i_write_done    = done;
    if (a < NT) msh[a] = CW'(d);
    if (done) mpend = 1'b1;
    @(negedge clk);
    bus.i_write_enable = 1'b0;
    bus.i_write_done   = 1'b0;
  endtask

  task automatic commit();
    @(negedge clk);
    bus.i_write_done = 1'b1;
    mpend = 1'b1;
    @(negedge clk);
    bus.i_write_done = 1'b0;
  endtask

  task automatic send_sample(input int x, input int lat);
    @(negedge clk);
    bus.i_sample_valid  = 1'b1;
    bus.i_signal_sample = DW'(x);
    if (mpend) begin
      for (int t = 0; t < NT; t++) mh[t] = msh[t];
      mpend = 1'b0;
    end
    for (int t = NT - 1; t > 0; t--) hist[t] = hist[t-1];
    hist[0] = DW'(x);
    exp_q.push_back(model_out());
    lat_q.push_back(lat);
    @(posedge clk);
    #1;
    acc_q.push_back(raw_cycle);
    @(negedge clk);
    bus.i_sample_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete(); acc_q.delete(); lat_q.delete();
  endtask

  task automatic send_wait(input int x);
    send_sample(x, NT + 1);
    wait_drain();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_out"},     longint'($signed(bus.o_signal_sample)), 0);
    check({tag, "_valid"},   bus.o_sample_valid, 0);
    check({tag, "_busy"},    bus.o_busy, 0);
    check({tag, "_overrun"}, bus.o_overrun, 0);
    check({tag, "_state"},   state_dbg, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int v0;
  int o0;

  initial begin
    rst = 1'b0;
    clk_enable = 1'b1;
    bus.i_sample_valid = 1'b0; bus.i_signal_sample = '0;
    bus.i_write_enable = 1'b0; bus.i_write_address = '0;
    bus.i_coeffs_in = '0;      bus.i_write_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk); rst = 1'b1;

    // Single-tap gain of one half: 1000, 3, -3 -> 500, 2, -1.
    write_coeff(0, 16384, 1'b0);
    commit();
    send_wait(1000);
    send_wait(3);
    send_wait(-3);

    // Ramp impulse response; an out-of-range address must not disturb it.
    for (int t = 0; t < NT; t++) write_coeff(t, 1024 * (t + 1), 1'b0);
    write_coeff(NT, 77, 1'b0);
    commit();
    send_wait(32767);
    for (int t = 0; t < NT; t++) send_wait(0);

    // Saturation in both directions.
    for (int t = 0; t < NT; t++) write_coeff(t, 32767, 1'b0);
    commit();
    for (int t = 0; t < NT; t++) send_wait(32767);
    for (int t = 0; t < NT; t++) send_wait(-32768);

    // Double buffering; the last write coincides with the done pulse.
    for (int t = 1; t < NT; t++) write_coeff(t, 0, 1'b0);
    write_coeff(0, 16384, 1'b1);
    send_wait(2000);
    send_sample(2000, NT + 1);
    write_coeff(0, 32767, 1'b0);
    wait_drain();
    send_sample(2000, NT + 1);
    commit();
    wait_drain();
    send_wait(2000);

    // Overrun: a second strobe two cycles after the accept is dropped.
    write_coeff(0, 16384, 1'b1);
    v0 = valid_cnt; o0 = ovr_cnt;
    send_sample(1000, NT + 1);
    @(negedge clk);
    bus.i_sample_valid = 1'b1; bus.i_signal_sample = DW'(777);
    @(negedge clk);
    bus.i_sample_valid = 1'b0;
    wait_drain();
    check("overrun_pulses", ovr_cnt - o0, 1);
    check("overrun_valids", valid_cnt - v0, 1);

    // Five disabled cycles mid-MAC delay the result by exactly five cycles.
    send_sample(1200, NT + 1 + 5);
    @(negedge clk); clk_enable = 1'b0;
    repeat (5) @(negedge clk);
    check("stall_busy", bus.o_busy, 1);
    clk_enable = 1'b1;
    wait_drain();

    // Reset mid-MAC abandons the computation and clears both banks.
    v0 = valid_cnt;
    send_sample(1000, NT + 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete(); acc_q.delete(); lat_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("midreset_no_valid", valid_cnt - v0, 0);
    send_wait(5000);
    check("zero_coeff_out", longint'($signed(bus.o_signal_sample)), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
